tbt_matrix_loader: RTL and testbench

// Upstream/downstream sequencer for the 2x2 FP32 matrix adder stage. Collects eight
// 32-bit words from a valid/ready input stream (A then B, row-major), presents them

---
 rtl/tbt_matrix_loader.sv | 189 ++++++++++++++++++
 tb/tb_tbt_matrix_loader.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tbt_matrix_loader.sv
// tbt_matrix_loader: word-stream sequencer around the 2x2 FP32 matrix adder.
// Gathers eight input words into packed A/B, strobes the adder, captures and
// acknowledges the packed sum, then streams the four result words out.
// Optional feature macro: TBT_LOADER_TIMEOUT_EN (abort a stuck adder wait).
module tbt_matrix_loader #(
   parameter int unsigned WORD_W = 32
`ifdef TBT_LOADER_TIMEOUT_EN
   , parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [WORD_W-1:0]     in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [4*WORD_W-1:0]   A,
   output logic [4*WORD_W-1:0]   B,
   output logic                  A_stb,
   output logic                  B_stb,
   input  logic                  result_ready,
   input  logic [4*WORD_W-1:0]   result,
   output logic                  result_ack,
   output logic [WORD_W-1:0]     out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_last,
   output logic                  busy
`ifdef TBT_LOADER_TIMEOUT_EN
   , output logic                timeout_err
`endif
);

   localparam int unsigned MAT_W = 4 * WORD_W;

   typedef enum logic [2:0] {
      S_COLLECT,
      S_STROBE,
      S_WAIT_RES,
      S_ACK,
      S_WAIT_LOW,
      S_EMIT
   } state_t;

   state_t              state, state_n;
   logic [2:0]          cnt, cnt_n;
   logic [1:0]          idx, idx_n;
   logic [MAT_W-1:0]    res_reg, res_n;
   logic [MAT_W-1:0]    a_n, b_n;
   logic [WORD_W-1:0]   out_data_n;
   logic                ack_n;
   logic                accept;

`ifdef TBT_LOADER_TIMEOUT_EN
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMO_W-1:0]    tmo_cnt;
   logic                tmo_fire;
`endif

   // in_ready is only ever high in S_COLLECT, so it alone qualifies a transfer
   assign accept = in_valid && in_ready;

   // Next-state, datapath and next-output decode
   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      idx_n      = idx;
      res_n      = res_reg;
      a_n        = A;
      b_n        = B;
      out_data_n = out_data;
`ifdef TBT_LOADER_TIMEOUT_EN
      tmo_fire   = 1'b0;
`endif

      case (state)
         S_COLLECT: begin
            if (accept) begin
               for (int i = 0; i < 4; i++) begin
                  if (cnt[1:0] == 2'(i)) begin
                     if (cnt[2]) b_n[i*WORD_W +: WORD_W] = in_data;
                     else        a_n[i*WORD_W +: WORD_W] = in_data;
                  end
               end
               if (cnt == 3'd7) begin
                  state_n = S_STROBE;
                  cnt_n   = 3'd0;
               end else begin
                  cnt_n = cnt + 3'd1;
               end
            end
         end
         S_STROBE: state_n = S_WAIT_RES;
         S_WAIT_RES: begin
            if (result_ready) begin
               res_n   = result;
               state_n = S_ACK;
            end
`ifdef TBT_LOADER_TIMEOUT_EN
            else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
               tmo_fire = 1'b1;
               state_n  = S_COLLECT;
            end
`endif
         end
         S_ACK: state_n = S_WAIT_LOW;
         // the adder keeps result_ready up briefly after the ack; wait it out
         S_WAIT_LOW: begin
            if (!result_ready) begin
               state_n = S_EMIT;
               idx_n   = 2'd0;
            end
         end
         S_EMIT: begin
            if (out_ready) begin
               idx_n = idx + 2'd1;
               if (idx == 2'd3) state_n = S_COLLECT;
            end
         end
         default: state_n = S_COLLECT;
      endcase

      if (state_n == S_EMIT) begin
         for (int i = 0; i < 4; i++) begin
            if (idx_n == 2'(i)) out_data_n = res_reg[i*WORD_W +: WORD_W];
         end
      end

      ack_n = (state_n == S_ACK);
`ifdef TBT_LOADER_TIMEOUT_EN
      ack_n = ack_n || tmo_fire;
`endif
   end

   // State register and registered control outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_COLLECT;
         cnt        <= 3'd0;
         idx        <= 2'd0;
         in_ready   <= 1'b0;
         A_stb      <= 1'b0;
         B_stb      <= 1'b0;
         result_ack <= 1'b0;
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         idx        <= idx_n;
         in_ready   <= (state_n == S_COLLECT);
         A_stb      <= (state_n == S_STROBE);
         B_stb      <= (state_n == S_STROBE);
         result_ack <= ack_n;
         out_valid  <= (state_n == S_EMIT);
         out_last   <= (state_n == S_EMIT) && (idx_n == 2'd3);
         busy       <= !((state_n == S_COLLECT) && (cnt_n == 3'd0));
      end
   end

   // Matrix operand, captured result and output word registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         A        <= '0;
         B        <= '0;
         res_reg  <= '0;
         out_data <= '0;
      end else begin
         A        <= a_n;
         B        <= b_n;
         res_reg  <= res_n;
         out_data <= out_data_n;
      end
   end

`ifdef TBT_LOADER_TIMEOUT_EN
   // Cycles spent waiting for the adder, and the sticky abort flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tmo_cnt     <= '0;
         timeout_err <= 1'b0;
      end else begin
         tmo_cnt <= (state == S_WAIT_RES) ? tmo_cnt + TMO_W'(1) : '0;
         if (tmo_fire) timeout_err <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_tbt_matrix_loader.sv
// Bench for tbt_matrix_loader: plays host, adder and consumer. Directed table
// vectors plus random matrices; expected words come from the bench's own tables.
module tb_tbt_matrix_loader;

   logic          clk = 1'b0;
   logic          reset;
   logic [31:0]   in_data;
   logic          in_valid;
   logic          in_ready;
   logic [127:0]  A, B;
   logic          A_stb, B_stb;
   logic          result_ready;
   logic [127:0]  result;
   logic          result_ack;
   logic [31:0]   out_data;
   logic          out_valid;
   logic          out_ready;
   logic          out_last;
   logic          busy;
`ifdef TBT_LOADER_TIMEOUT_EN
   logic          timeout_err;
`endif

   int checks = 0;
   int errors = 0;
   int stb_cnt = 0;
   int ack_cnt = 0;
   int cyc = 0;

   typedef struct packed {
      logic [3:0][31:0] a;
      logic [3:0][31:0] b;
      logic [3:0][31:0] s;
      int gap;     // 0 none, 1 idle cycle before every word, 2 random
      int delay;   // cycles before the adder raises result_ready
      int hold;    // cycles result_ready stays high after the ack
      int stall;   // out_ready low cycles before the third word
   } vec_t;

   vec_t vecs [4];
   vec_t v;

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;
   always @(negedge clk) begin
      if (A_stb) stb_cnt++;
      if (result_ack) ack_cnt++;
   end

`ifdef TBT_LOADER_TIMEOUT_EN
   tbt_matrix_loader #(.WORD_W(32), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .reset(reset),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .A_stb(A_stb), .B_stb(B_stb),
      .result_ready(result_ready), .result(result), .result_ack(result_ack),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .busy(busy),
      .timeout_err(timeout_err)
   );
`else
   tbt_matrix_loader #(.WORD_W(32)) dut (
      .clk(clk), .reset(reset),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .A_stb(A_stb), .B_stb(B_stb),
      .result_ready(result_ready), .result(result), .result_ack(result_ack),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .busy(busy)
   );
`endif

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic bound_fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: wait bound expired", name);
   endtask

   task automatic send_word(input logic [31:0] w, input bit gap);
      int n = 0;
      if (gap) begin
         in_valid = 1'b0;
         @(negedge clk);
      end
      in_data  = w;
      in_valid = 1'b1;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) bound_fail("in_ready_wait");
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_ctl"}, {in_ready, A_stb, B_stb, result_ack, out_valid, out_last, busy}, '0);
      chk({tag, "_A"}, A, '0);
      chk({tag, "_B"}, B, '0);
      chk({tag, "_out_data"}, out_data, '0);
   endtask

   task automatic run_vec(input vec_t tv, input bit rnd_out);
      int n, k, stall_left, ack_cyc, valid_cyc, ack_lat;
      logic [3:0][31:0] got;
      logic [3:0] last_got;
      logic [31:0] held_data;
      bit held, ir_bad, or_now, gap;
      stb_cnt = 0;
      ack_cnt = 0;
      got = '0;
      last_got = '0;
      for (int i = 0; i < 8; i++) begin
         gap = (tv.gap == 1) || (tv.gap == 2 && $urandom_range(0, 1) == 1);
         if (i == 7) chk("no_early_stb", A_stb, 1'b0);
         send_word(i < 4 ? tv.a[i] : tv.b[i-4], gap);
         if (i == 0) chk("busy_mid_collect", busy, 1'b1);
      end
      // the cycle right after the 8th accept
      chk("strobe", {A_stb, B_stb, in_ready, busy}, 4'b1101);
      chk("A_pack", A, tv.a);
      chk("B_pack", B, tv.b);
      // adder side
      repeat (tv.delay) @(negedge clk);
      result = tv.s;
      result_ready = 1'b1;
      ack_lat = 0;
      while (!result_ack && ack_lat < 50) begin
         @(negedge clk);
         ack_lat++;
      end
      if (!result_ack) bound_fail("ack_wait");
      chk("ack_latency", 32'(ack_lat), (tv.delay == 0) ? 32'd2 : 32'd1);
      ack_cyc = cyc;
      result = ~tv.s;   // anything captured from here on would be stale
      for (int h = 0; h < tv.hold; h++) @(negedge clk);
      result_ready = 1'b0;
      // consumer side
      k = 0; n = 0; stall_left = tv.stall; held = 0; ir_bad = 0; valid_cyc = -1;
      while (k < 4 && n < 300) begin
         if (held) chk("stall_hold", {out_valid, out_data}, {1'b1, held_data});
         if (in_ready) ir_bad = 1;
         if (out_valid && valid_cyc < 0) valid_cyc = cyc;
         if (out_valid && k == 2 && stall_left > 0) begin
            or_now = 1'b0;
            stall_left--;
         end else if (rnd_out) begin
            or_now = ($urandom_range(0, 2) != 0);
         end else begin
            or_now = 1'b1;
         end
         out_ready = or_now;
         held = out_valid && !or_now;
         held_data = out_data;
         if (out_valid && or_now) begin
            got[k] = out_data;
            last_got[k] = out_last;
            k++;
         end
         @(negedge clk);
         n++;
      end
      out_ready = 1'b0;
      if (k < 4) bound_fail("emit_wait");
      chk("out_words", got, tv.s);
      chk("out_last", last_got, 4'b1000);
      chk("in_ready_low_while_busy", ir_bad, 1'b0);
      chk("emit_latency", (valid_cyc - ack_cyc) >= 2, 1'b1);
      chk("stb_count", 32'(stb_cnt), 32'd1);
      chk("ack_count", 32'(ack_cnt), 32'd1);
      chk("idle_after", {out_valid, out_last, in_ready, busy}, 4'b0010);
   endtask

   initial begin
      reset = 1'b1;
      in_data = '0; in_valid = 1'b0;
      result = '0; result_ready = 1'b0; out_ready = 1'b0;

      // directed vectors
      for (int i = 0; i < 4; i++) begin
         vecs[0].a[i] = 32'h3F800000;
         vecs[0].b[i] = 32'h40000000;
         vecs[0].s[i] = 32'h40400000;
         vecs[1].s[i] = 32'h40A00000;
         vecs[2].a[i] = 32'h3FC00000;
         vecs[2].b[i] = 32'h3F000000;
         vecs[2].s[i] = 32'h40000000;
         vecs[3].a[i] = 32'h00000000;
      end
      vecs[1].a[0] = 32'h3F800000; vecs[1].a[1] = 32'h40000000;
      vecs[1].a[2] = 32'h40400000; vecs[1].a[3] = 32'h40800000;
      vecs[1].b[0] = 32'h40800000; vecs[1].b[1] = 32'h40400000;
      vecs[1].b[2] = 32'h40000000; vecs[1].b[3] = 32'h3F800000;
      vecs[3].b[0] = 32'h3F800000; vecs[3].b[1] = 32'h40000000;
      vecs[3].b[2] = 32'h40400000; vecs[3].b[3] = 32'h40800000;
      vecs[3].s = vecs[3].b;
      vecs[0].gap = 0; vecs[0].delay = 2; vecs[0].hold = 1; vecs[0].stall = 0;
      vecs[1].gap = 0; vecs[1].delay = 0; vecs[1].hold = 1; vecs[1].stall = 0;
      vecs[2].gap = 1; vecs[2].delay = 1; vecs[2].hold = 1; vecs[2].stall = 0;
      vecs[3].gap = 0; vecs[3].delay = 3; vecs[3].hold = 3; vecs[3].stall = 10;

      // reset state
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      reset = 1'b0;
      @(negedge clk);
      chk("in_ready_after_reset", {in_ready, busy}, 2'b10);

      for (int i = 0; i < 4; i++) run_vec(vecs[i], 1'b0);

      // partial matrix discarded by reset
      for (int i = 0; i < 3; i++) send_word(32'hDEAD0000 + 32'(i), 1'b0);
      reset = 1'b1;
      #1;
      check_all_zero("reset_partial");
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      run_vec(vecs[1], 1'b0);

      // reset while waiting on the adder
      for (int i = 0; i < 8; i++) send_word(32'h11110000 + 32'(i), 1'b0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      #1;
      check_all_zero("reset_wait_res");
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      run_vec(vecs[0], 1'b0);

      // random matrices
      for (int r = 0; r < 25; r++) begin
         for (int i = 0; i < 4; i++) begin
            v.a[i] = $urandom;
            v.b[i] = $urandom;
            v.s[i] = $urandom;
         end
         v.gap = 2;
         v.delay = $urandom_range(0, 3);
         v.hold = $urandom_range(0, 2);
         v.stall = $urandom_range(0, 4);
         run_vec(v, 1'b1);
      end

`ifdef TBT_LOADER_TIMEOUT_EN
      begin
         int n;
         for (int i = 0; i < 8; i++) send_word(32'h22220000 + 32'(i), 1'b0);
         n = 0;
         while (!timeout_err && n < 100) begin
            @(negedge clk);
            n++;
         end
         if (!timeout_err) bound_fail("timeout_wait");
         chk("timeout_cycles", (n >= 16) && (n <= 17), 1'b1);
         chk("timeout_flush", {result_ack, in_ready, out_valid}, 3'b110);
         @(negedge clk);
         chk("timeout_sticky", {timeout_err, result_ack, out_valid}, 3'b100);
         reset = 1'b1;
         #1;
         chk("timeout_cleared", timeout_err, 1'b0);
         @(negedge clk);
         reset = 1'b0;
         @(negedge clk);
      end
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
